// File: rtl/pll_reconfig_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pll_reconfig_ctrl                                            |
// | Description : Retune controller for a reconfigurable PLL. A frequency      |
// |               request is turned into a feedback count m (smallest multiple |
// |               of the requested LO frequency that lands in the VCO window)  |
// |               and a matching post-divider c0. The block then loads them    |
// |               into the reconfig engine, pulses the PLL reset and qualifies |
// |               lock before reporting locked.                                |
// | Option      : PLL_RECFG_PENDING_EN - when defined, a request arriving      |
// |               while a retune is in progress is held in a one-deep pending  |
// |               slot and started once the controller is idle again. When     |
// |               undefined, such requests are dropped.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   if_freq     in   [8:0] requested LO frequency in MHz
//   freq_strobe in   one-cycle retune request
//   busy        in   reconfig engine busy
//   pll_lock    in   raw PLL lock indicator
//   m           out  [8:0] feedback count
//   n           out  [8:0] pre-divide count (fixed at N_DIV)
//   c0          out  [8:0] post-divide count
//   strobe      out  one-cycle reconfig load pulse
//   pll_reset   out  one-cycle PLL reset pulse
//   locked      out  retune complete and lock qualified
//   err         out  last request rejected or timed out
//
// M_MAX must not exceed 511 because m is a 9-bit port.

module pll_reconfig_ctrl #(
  parameter int N_DIV        = 50,
  parameter int M_MIN        = 300,
  parameter int M_MAX        = 511,
  parameter int C_MAX        = 255,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [8:0] if_freq,
  input  logic       freq_strobe,
  input  logic       busy,
  input  logic       pll_lock,
  output logic [8:0] m,
  output logic [8:0] n,
  output logic [8:0] c0,
  output logic       strobe,
  output logic       pll_reset,
  output logic       locked,
  output logic       err
);

  localparam int         TMR_W     = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [9:0] M_MIN_V   = 10'(M_MIN);
  localparam logic [9:0] M_MAX_V   = 10'(M_MAX);
  localparam logic [8:0] C_MAX_V   = 9'(C_MAX);
  localparam logic [8:0] N_DIV_V   = 9'(N_DIV);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  // Lock is qualified on the 16th consecutive high sample.
  localparam logic [4:0] LOCK_LAST = 5'd15;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEARCH    = 3'd1,
    S_LOAD      = 3'd2,
    S_BLANK     = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_PLL_RST   = 3'd5,
    S_WAIT_LOCK = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [8:0]       f_q, f_d;
  // 10 bits: acc is only advanced while below M_MIN (<= 511), so acc + f
  // stays below 1023 and the range test never sees a wrapped value.
  logic [9:0]       acc_q, acc_d;
  logic [8:0]       c_q, c_d;
  logic [8:0]       m_q, m_d;
  logic [8:0]       c0_q, c0_d;
  // Shared counter: blanking cycles in BLANK, consecutive lock samples in
  // WAIT_LOCK.
  logic [4:0]       cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             strobe_q, strobe_d;
  logic             pll_reset_q, pll_reset_d;

  // Request seen by IDLE: a live strobe, or (optionally) a held request.
  logic             req_v;
  logic [8:0]       req_f;

`ifdef PLL_RECFG_PENDING_EN
  logic             pend_q, pend_d;
  logic [8:0]       pend_f_q, pend_f_d;

  always_comb begin
    req_v    = freq_strobe;
    req_f    = if_freq;
    pend_d   = pend_q;
    pend_f_d = pend_f_q;
    // A live strobe in IDLE is the newest request and wins over a held one.
    if (!freq_strobe && pend_q) begin
      req_v = 1'b1;
      req_f = pend_f_q;
    end
    if (state_q == S_IDLE) begin
      pend_d = 1'b0;
    end else if (freq_strobe) begin
      pend_d   = 1'b1;
      pend_f_d = if_freq;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q   <= 1'b0;
      pend_f_q <= '0;
    end else begin
      pend_q   <= pend_d;
      pend_f_q <= pend_f_d;
    end
  end
`else
  always_comb begin
    req_v = freq_strobe;
    req_f = if_freq;
  end
`endif

  always_comb begin
    state_d     = state_q;
    f_d         = f_q;
    acc_d       = acc_q;
    c_d         = c_q;
    m_d         = m_q;
    c0_d        = c0_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    locked_d    = locked_q;
    err_d       = err_q;
    strobe_d    = 1'b0;
    pll_reset_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_v && (req_f != 9'd0)) begin
          f_d      = req_f;
          acc_d    = {1'b0, req_f};
          c_d      = 9'd1;
          locked_d = 1'b0;
          err_d    = 1'b0;
          state_d  = S_SEARCH;
        end else begin
          if (req_v) begin
            err_d = 1'b1;
          end
          if (!pll_lock) begin
            locked_d = 1'b0;
          end
        end
      end

      S_SEARCH: begin
        if (acc_q > M_MAX_V) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (acc_q >= M_MIN_V) begin
          m_d     = acc_q[8:0];
          c0_d    = c_q;
          state_d = S_LOAD;
        end else if (c_q == C_MAX_V) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          acc_d = acc_q + {1'b0, f_q};
          c_d   = c_q + 9'd1;
        end
      end

      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_BLANK;
      end

      // The engine may not have raised busy yet right after the load pulse.
      S_BLANK: begin
        if (cnt_q == 5'd1) begin
          cnt_d   = '0;
          state_d = S_WAIT_BUSY;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_WAIT_BUSY: begin
        if (!busy) begin
          state_d = S_PLL_RST;
        end
      end

      S_PLL_RST: begin
        cnt_d   = '0;
        tmr_d   = '0;
        state_d = S_WAIT_LOCK;
      end

      S_WAIT_LOCK: begin
        if (pll_lock && (cnt_q == LOCK_LAST)) begin
          locked_d = 1'b1;
          state_d  = S_IDLE;
        end else if (tmr_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
          cnt_d = pll_lock ? (cnt_q + 5'd1) : 5'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pulses are registered so they come straight from flops.
    strobe_d    = (state_d == S_LOAD);
    pll_reset_d = (state_d == S_PLL_RST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      f_q         <= '0;
      acc_q       <= '0;
      c_q         <= '0;
      m_q         <= '0;
      c0_q        <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      strobe_q    <= 1'b0;
      pll_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      f_q         <= f_d;
      acc_q       <= acc_d;
      c_q         <= c_d;
      m_q         <= m_d;
      c0_q        <= c0_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      strobe_q    <= strobe_d;
      pll_reset_q <= pll_reset_d;
    end
  end

  assign m         = m_q;
  assign n         = N_DIV_V;
  assign c0        = c0_q;
  assign strobe    = strobe_q;
  assign pll_reset = pll_reset_q;
  assign locked    = locked_q;
  assign err       = err_q;

endmodule

`default_nettype wire
